// File: rtl/dmem_ctrl_pkg.sv
// Shared types, op codes and lane helpers for the MEM-stage data memory controller.
// State encodings live here next to the op codes they serve.
package dmem_ctrl_pkg;

  localparam int ALUOP_W = 8;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t MINIMIPS32_LB  = 8'h90;
  localparam aluop_t MINIMIPS32_LBU = 8'h91;
  localparam aluop_t MINIMIPS32_LH  = 8'h92;
  localparam aluop_t MINIMIPS32_LHU = 8'h93;
  localparam aluop_t MINIMIPS32_LW  = 8'h94;
  localparam aluop_t MINIMIPS32_SB  = 8'h98;
  localparam aluop_t MINIMIPS32_SH  = 8'h99;
  localparam aluop_t MINIMIPS32_SW  = 8'h9A;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  function automatic logic is_load(aluop_t op);
    return op == MINIMIPS32_LB || op == MINIMIPS32_LBU ||
           op == MINIMIPS32_LH || op == MINIMIPS32_LHU ||
           op == MINIMIPS32_LW;
  endfunction

  function automatic logic is_store(aluop_t op);
    return op == MINIMIPS32_SB || op == MINIMIPS32_SH ||
           op == MINIMIPS32_SW;
  endfunction

  function automatic logic [3:0] st_strb(aluop_t op, logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      (op == MINIMIPS32_SB): s = 4'b0001 << a;
      (op == MINIMIPS32_SH): s = a[1] ? 4'b1100 : 4'b0011;
      (op == MINIMIPS32_SW): s = 4'b1111;
      default:               s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] st_wdata(aluop_t op,
                                           logic [31:0] d);
    logic [31:0] w;
    w = ZERO_WORD;
    unique case (1'b1)
      (op == MINIMIPS32_SB): w = {4{d[7:0]}};
      (op == MINIMIPS32_SH): w = {2{d[15:0]}};
      (op == MINIMIPS32_SW): w = d;
      default:               w = ZERO_WORD;
    endcase
    return w;
  endfunction

  function automatic logic misaligned(aluop_t op, logic [1:0] a);
    logic half, word;
    half = op == MINIMIPS32_LH || op == MINIMIPS32_LHU ||
           op == MINIMIPS32_SH;
    word = op == MINIMIPS32_LW || op == MINIMIPS32_SW;
    return (half && a[0]) || (word && a != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// MEM-stage / data SRAM signal bundle.
// master = controller view, slave = pipeline + SRAM view.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  aluop_t      mem_aluop;
  logic [31:0] mem_wd;
  logic [31:0] mem_din;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_req;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        addr_exc;

  modport master (
    input  mem_aluop, mem_wd, mem_din,
    input  dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr,
    output dm_wstrb, dm_wdata,
    output stall_req, ld_data,
    output ld_valid, addr_exc
  );

  modport slave (
    output mem_aluop, mem_wd, mem_din,
    output dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr,
    input  dm_wstrb, dm_wdata,
    input  stall_req, ld_data,
    input  ld_valid, addr_exc
  );

endinterface

// File: rtl/dmem_ctrl_load_align.sv
// Load lane select and sign/zero extension of a raw SRAM word.
// Halfword lane follows a[1] only; byte lane follows a[1:0].
module load_align
  import dmem_ctrl_pkg::*;
(
  input  aluop_t      op_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata_i[{a_i, 3'b000} +: 8];
    h      = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = ZERO_WORD;
    unique case (1'b1)
      (op_i == MINIMIPS32_LB):  data_o = {{24{b[7]}}, b};
      (op_i == MINIMIPS32_LBU): data_o = {24'h0, b};
      (op_i == MINIMIPS32_LH):  data_o = {{16{h[15]}}, h};
      (op_i == MINIMIPS32_LHU): data_o = {16'h0, h};
      (op_i == MINIMIPS32_LW):  data_o = rdata_i;
      default:                  data_o = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: IDLE -> REQ -> DONE per access.
// MEM_ALIGN_EXC_EN enables the misaligned-address flag.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input logic         cpu_clk_50M,
  input logic         cpu_rst_n,
  dmem_ctrl_if.master bus
);

  dm_state_e   state_q, state_d;
  aluop_t      op_q;
  logic [29:0] waddr_q;
  logic [1:0]  lo_q;
  logic        we_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_data_q;
  logic [31:0] aligned;
  logic        ldst, exc, latch, cap, stall;

  assign ldst = is_load(bus.mem_aluop) |
                is_store(bus.mem_aluop);

`ifdef MEM_ALIGN_EXC_EN
  assign exc = ldst & misaligned(bus.mem_aluop,
                                 bus.mem_wd[1:0]);
`else
  assign exc = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cap     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ldst && !exc) begin
          state_d = REQ;
          latch   = 1'b1;
          stall   = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.dm_ack) begin
          state_d = DONE;
          cap     = is_load(op_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q   <= IDLE;
      op_q      <= '0;
      waddr_q   <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= ZERO_WORD;
      ld_data_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (latch) begin
        op_q    <= bus.mem_aluop;
        waddr_q <= bus.mem_wd[31:2];
        lo_q    <= bus.mem_wd[1:0];
        we_q    <= is_store(bus.mem_aluop);
        strb_q  <= st_strb(bus.mem_aluop, bus.mem_wd[1:0]);
        wdata_q <= st_wdata(bus.mem_aluop, bus.mem_din);
      end
      if (cap) ld_data_q <= aligned;
    end
  end

  load_align u_load_align (
    .op_i    (op_q),
    .a_i     (lo_q),
    .rdata_i (bus.dm_rdata),
    .data_o  (aligned)
  );

  logic in_req;
  assign in_req = state_q == REQ;

  // Bus outputs are gated by REQ so nothing stale leaks between accesses.
  assign bus.dm_req    = in_req;
  assign bus.dm_we     = in_req & we_q;
  assign bus.dm_addr   = in_req ? {waddr_q, 2'b00} : ZERO_WORD;
  assign bus.dm_wstrb  = in_req ? strb_q : 4'b0000;
  assign bus.dm_wdata  = in_req ? wdata_q : ZERO_WORD;
  assign bus.ld_data   = ld_data_q;
  assign bus.ld_valid  = (state_q == DONE) & is_load(op_q);
  // The IDLE terms look at live inputs, so hold them low during reset.
  assign bus.stall_req = stall & cpu_rst_n;
  assign bus.addr_exc  = exc & (state_q == IDLE) & cpu_rst_n;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table, random accesses
// against a lane-arithmetic model, and reset / stray-ack sequences.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  dmem_ctrl_if bus();

  dmem_ctrl dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .bus         (bus)
  );

  typedef struct {
    aluop_t      op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
    int          nwait;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  int errs = 0;
  int checks = 0;
  logic [31:0] last_ld = 32'h0;
  vec_t tbl[$];

  localparam aluop_t NOP = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic m_is_load(aluop_t op);
    return op inside {MINIMIPS32_LB, MINIMIPS32_LBU,
                      MINIMIPS32_LH, MINIMIPS32_LHU,
                      MINIMIPS32_LW};
  endfunction

  function automatic logic [3:0] m_strb(aluop_t op,
                                        logic [31:0] a);
    int s;
    s = 0;
    if (op == MINIMIPS32_SB) s = 1 << (a % 4);
    if (op == MINIMIPS32_SH) s = 3 << (2 * ((a / 2) % 2));
    if (op == MINIMIPS32_SW) s = 15;
    return 4'(s);
  endfunction

  function automatic logic [31:0] m_wdata(aluop_t op,
                                          logic [31:0] d);
    if (op == MINIMIPS32_SB) return (d % 256) * 32'h0101_0101;
    if (op == MINIMIPS32_SH) return (d % 65536) * 32'h0001_0001;
    if (op == MINIMIPS32_SW) return d;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(aluop_t op,
                                         logic [31:0] a,
                                         logic [31:0] r);
    longint v;
    v = longint'(r);
    case (op)
      MINIMIPS32_LB, MINIMIPS32_LBU: begin
        v = (v >> (8 * (a % 4))) % 256;
        if (op == MINIMIPS32_LB && v >= 128) v = v - 256;
      end
      MINIMIPS32_LH, MINIMIPS32_LHU: begin
        v = (v >> (16 * ((a / 2) % 2))) % 65536;
        if (op == MINIMIPS32_LH && v >= 32768) v = v - 65536;
      end
      default: v = longint'(r);
    endcase
    return 32'(v);
  endfunction

  function automatic vec_t mk(aluop_t op, logic [31:0] a,
                              logic [31:0] d, logic [31:0] r,
                              int nw, logic [31:0] ea,
                              logic [3:0] es, logic [31:0] ew,
                              logic [31:0] el);
    vec_t v;
    v.op = op; v.addr = a; v.din = d; v.rdata = r;
    v.nwait = nw; v.e_addr = ea; v.e_strb = es;
    v.e_wdata = ew; v.e_ld = el;
    return v;
  endfunction

  function automatic vec_t mk_model(aluop_t op, logic [31:0] a,
                                    logic [31:0] d,
                                    logic [31:0] r, int nw);
    return mk(op, a, d, r, nw, a - (a % 4), m_strb(op, a),
              m_wdata(op, d), m_load(op, a, r));
  endfunction

  // Caller sits just after a rising edge; returns the same way.
  task automatic run_access(input vec_t v, input string nm);
    logic ld;
    logic st;
    ld = m_is_load(v.op);
    st = !ld;
    bus.mem_aluop = v.op;
    bus.mem_wd    = v.addr;
    bus.mem_din   = v.din;
    bus.dm_ack    = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_stall"}, 32'(bus.stall_req), 32'd1);
    chk({nm, ".idle_req"}, 32'(bus.dm_req), 32'd0);
    chk({nm, ".addr_exc"}, 32'(bus.addr_exc), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= v.nwait; k++) begin
      bus.dm_ack   = (k == v.nwait);
      bus.dm_rdata = bus.dm_ack ? v.rdata : $urandom;
      @(negedge clk);
      chk({nm, ".req"}, 32'(bus.dm_req), 32'd1);
      chk({nm, ".we"}, 32'(bus.dm_we), 32'(st));
      chk({nm, ".addr"}, bus.dm_addr, v.e_addr);
      chk({nm, ".strb"}, 32'(bus.dm_wstrb),
          32'(st ? v.e_strb : 4'b0000));
      chk({nm, ".wdata"}, bus.dm_wdata,
          st ? v.e_wdata : 32'h0);
      chk({nm, ".req_stall"}, 32'(bus.stall_req), 32'd1);
      chk({nm, ".req_valid"}, 32'(bus.ld_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.dm_ack = 1'b0;
    @(negedge clk);
    if (ld) last_ld = v.e_ld;
    chk({nm, ".done_req"}, 32'(bus.dm_req), 32'd0);
    chk({nm, ".done_stall"}, 32'(bus.stall_req), 32'd0);
    chk({nm, ".ld_valid"}, 32'(bus.ld_valid), 32'(ld));
    chk({nm, ".ld_data"}, bus.ld_data, last_ld);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    aluop_t ops[8];
    ops = '{MINIMIPS32_LB, MINIMIPS32_LBU, MINIMIPS32_LH,
            MINIMIPS32_LHU, MINIMIPS32_LW, MINIMIPS32_SB,
            MINIMIPS32_SH, MINIMIPS32_SW};

    tbl.push_back(mk(MINIMIPS32_SB, 32'h23, 32'h0000_00A5, 32'h0, 0,
                     32'h20, 4'b1000, 32'hA5A5_A5A5, 32'h0));
    tbl.push_back(mk(MINIMIPS32_LB, 32'h41, 32'h0, 32'h1234_80FF, 0,
                     32'h40, 4'b0000, 32'h0, 32'hFFFF_FF80));
    tbl.push_back(mk(MINIMIPS32_LBU, 32'h41, 32'h0, 32'h1234_80FF, 0,
                     32'h40, 4'b0000, 32'h0, 32'h0000_0080));
    tbl.push_back(mk(MINIMIPS32_LH, 32'h42, 32'h0, 32'h8001_0000, 3,
                     32'h40, 4'b0000, 32'h0, 32'hFFFF_8001));
    tbl.push_back(mk(MINIMIPS32_LHU, 32'h42, 32'h0, 32'h8001_0000, 1,
                     32'h40, 4'b0000, 32'h0, 32'h0000_8001));
    tbl.push_back(mk(MINIMIPS32_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
                     32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF));
    tbl.push_back(mk(MINIMIPS32_SW, 32'h104, 32'hCAFE_F00D, 32'h0, 0,
                     32'h104, 4'b1111, 32'hCAFE_F00D, 32'h0));
    tbl.push_back(mk(MINIMIPS32_SH, 32'h0A, 32'h1234_ABCD, 32'h0, 2,
                     32'h08, 4'b1100, 32'hABCD_ABCD, 32'h0));
    tbl.push_back(mk(MINIMIPS32_SH, 32'h0C, 32'h5555_7F01, 32'h0, 0,
                     32'h0C, 4'b0011, 32'h7F01_7F01, 32'h0));
    tbl.push_back(mk(MINIMIPS32_LB, 32'h13, 32'h0, 32'h7F00_0000, 0,
                     32'h10, 4'b0000, 32'h0, 32'h0000_007F));
    tbl.push_back(mk(MINIMIPS32_LH, 32'h10, 32'h0, 32'h0000_F00F, 2,
                     32'h10, 4'b0000, 32'h0, 32'hFFFF_F00F));
`ifndef MEM_ALIGN_EXC_EN
    tbl.push_back(mk(MINIMIPS32_LW, 32'h06, 32'h0, 32'h0BAD_CAFE, 0,
                     32'h04, 4'b0000, 32'h0, 32'h0BAD_CAFE));
    tbl.push_back(mk(MINIMIPS32_SH, 32'h0B, 32'h0000_BEEF, 32'h0, 0,
                     32'h08, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    tbl.push_back(mk(MINIMIPS32_LHU, 32'h43, 32'h0, 32'hA5A5_0000, 1,
                     32'h40, 4'b0000, 32'h0, 32'h0000_A5A5));
`endif

    bus.mem_aluop = MINIMIPS32_LW;
    bus.mem_wd    = 32'h0;
    bus.mem_din   = 32'h0;
    bus.dm_ack    = 1'b0;
    bus.dm_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(bus.stall_req), 32'd0);
    chk("rst.req", 32'(bus.dm_req), 32'd0);
    chk("rst.we", 32'(bus.dm_we), 32'd0);
    chk("rst.addr", bus.dm_addr, 32'h0);
    chk("rst.strb", 32'(bus.dm_wstrb), 32'd0);
    chk("rst.wdata", bus.dm_wdata, 32'h0);
    chk("rst.ld_data", bus.ld_data, 32'h0);
    chk("rst.ld_valid", 32'(bus.ld_valid), 32'd0);
    chk("rst.addr_exc", 32'(bus.addr_exc), 32'd0);
    @(posedge clk); #1;
    bus.mem_aluop = NOP;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_access(tbl[i], $sformatf("vec%0d", i));

    bus.mem_aluop = NOP;
    for (int i = 0; i < 2; i++) begin
      bus.dm_ack   = 1'b1;
      bus.dm_rdata = $urandom;
      @(negedge clk);
      chk("stray_ack.req", 32'(bus.dm_req), 32'd0);
      chk("stray_ack.valid", 32'(bus.ld_valid), 32'd0);
      chk("stray_ack.ld_data", bus.ld_data, last_ld);
      @(posedge clk); #1;
    end
    bus.dm_ack = 1'b0;

`ifdef MEM_ALIGN_EXC_EN
    bus.mem_aluop = MINIMIPS32_LW;
    bus.mem_wd    = 32'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("align.exc", 32'(bus.addr_exc), 32'd1);
      chk("align.stall", 32'(bus.stall_req), 32'd0);
      chk("align.req", 32'(bus.dm_req), 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_aluop = NOP;
    @(negedge clk);
    chk("align.clear", 32'(bus.addr_exc), 32'd0);
    @(posedge clk); #1;
`endif

    bus.mem_aluop = MINIMIPS32_SW;
    bus.mem_wd    = 32'h10;
    bus.mem_din   = 32'h1111_2222;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.req_before", 32'(bus.dm_req), 32'd1);
    #1;
    rst_n = 1'b0;
    bus.mem_aluop = NOP;
    #1;
    chk("midrst.req", 32'(bus.dm_req), 32'd0);
    chk("midrst.we", 32'(bus.dm_we), 32'd0);
    chk("midrst.addr", bus.dm_addr, 32'h0);
    chk("midrst.stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_ld = 32'h0;
    for (int i = 0; i < 2; i++) begin
      bus.dm_ack   = 1'b1;
      bus.dm_rdata = $urandom;
      @(negedge clk);
      chk("midrst.late_ack_req", 32'(bus.dm_req), 32'd0);
      chk("midrst.late_ack_valid", 32'(bus.ld_valid), 32'd0);
      chk("midrst.ld_data", bus.ld_data, 32'h0);
      @(posedge clk); #1;
    end
    bus.dm_ack = 1'b0;
    run_access(mk(MINIMIPS32_LW, 32'h20, 32'h0, 32'h0F0F_1234, 0,
                  32'h20, 4'b0000, 32'h0, 32'h0F0F_1234), "post_rst");

    for (int i = 0; i < 40; i++) begin
      aluop_t op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
`ifdef MEM_ALIGN_EXC_EN
      if (op inside {MINIMIPS32_LH, MINIMIPS32_LHU, MINIMIPS32_SH})
        a = a - (a % 2);
      if (op inside {MINIMIPS32_LW, MINIMIPS32_SW})
        a = a - (a % 4);
`endif
      run_access(mk_model(op, a, $urandom, $urandom,
                          $urandom_range(0, 3)),
                 $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        bus.mem_aluop = NOP;
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Clock and reset: one clock, cpu_clk_50M; reset cpu_rst_n is asynchronous and active-low.
REQ-002 cpu_clk_50M  in  1  sole clock, all state on rising edge.
REQ-003 cpu_rst_n  in  1  asynchronous active-low reset.
REQ-004 mem_aluop  in  ALUOP_BUS  MEM-stage operation; loads LB/LBU/LH/LHU/LW, stores SB/SH/SW.
REQ-005 mem_wd  in  32  effective byte address of the MEM-stage access.
REQ-006 mem_din  in  32  store data, value in low bits.
REQ-007 dm_req  out  1  request to data SRAM, held until acknowledged.
REQ-008 dm_we  out  1  1 = write, 0 = read; valid while dm_req=1.
REQ-009 dm_addr  out  32  word address {addr[31:2],2'b00}.
REQ-010 dm_wstrb  out  4  byte strobes; bit i enables byte lane i (little-endian).
REQ-011 dm_wdata  out  32  lane-replicated store data.
REQ-012 dm_ack  in  1  SRAM completion; sampled only in state REQ.
REQ-013 dm_rdata  in  32  read word; valid in the same cycle as dm_ack.
REQ-014 stall_req  out  1  freezes IF..MEM while the access is in flight.
REQ-015 ld_data  out  32  aligned, extended load result for the WB path.
REQ-016 ld_valid  out  1  one-cycle pulse when ld_data holds a new load result.
REQ-017 addr_exc  out  1  misaligned-address flag (see Configuration).

Function
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 IDLE: if mem_aluop is a load/store, latch the op, address and data, and go to REQ; otherwise stay in IDLE.
REQ-020 stall_req = (IDLE and mem_aluop is a load/store) or state==REQ; stall_req=0 in DONE.
REQ-021 REQ: dm_req=1; dm_we, dm_addr, dm_wstrb and dm_wdata come from latched values and stay stable until dm_ack.
REQ-022 REQ with dm_ack=1: capture the aligned load into ld_data (loads only) and go to DONE.
REQ-023 DONE: ld_valid=1 for loads only; no new access starts; always go to IDLE.
REQ-024 Zero-wait SRAM (dm_ack in the first REQ cycle): op seen at cycle 0, dm_req at cycle 1, ld_valid at cycle 2, stall_req high for cycles 0-1.
REQ-025 Stores: SB uses dm_wstrb=1<<a[1:0] and dm_wdata={4{din[7:0]}}; SH uses a[1]?1100:0011 and {2{din[15:0]}}; SW uses 1111 and din.
REQ-026 Loads: select the byte (a[1:0]) or halfword (a[1]); LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-027 For reads dm_wstrb=0000; ld_data holds its value until the next load completes.
REQ-028 A dm_ack that arrives outside REQ is ignored.

Reset
REQ-029 Reset asserted forces IDLE immediately, including mid-access in REQ: dm_req=0, dm_we=0, dm_addr=0, dm_wstrb=0, dm_wdata=0, ld_data=0, ld_valid=0, addr_exc=0, stall_req=0.
REQ-030 After reset release, the first access starts in the cycle after a load/store is seen in IDLE.

Configuration
REQ-031 Macro MEM_ALIGN_EXC_EN, defined: in IDLE, LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, gives addr_exc=1 (combinational), no dm_req and stall_req=0; the FSM stays in IDLE.
REQ-032 Macro MEM_ALIGN_EXC_EN, undefined: addr_exc is tied to 0; halfword accesses ignore a[0] and word accesses ignore a[1:0].

Structure
REQ-033 ALUOP_BUS, MINIMIPS32_L*/S* codes, ZERO_WORD and RST_ENABLE come from defines.v; state encodings are added there too.
REQ-034 One sub-module, load_align: combinational lane select and extension (op, a[1:0], rdata -> ld_data).

Verification
REQ-035 Reset: SW to 0x10 with ack delayed 3 cycles, cpu_rst_n pulled low in REQ -> dm_req=0 asynchronously; later ack ignored; state IDLE.
REQ-036 SB din=0x000000A5 at 0x23 -> dm_addr=0x20, dm_wstrb=1000, dm_wdata=0xA5A5A5A5, dm_we=1.
REQ-037 LB at 0x41, rdata=0x1234_80FF, zero-wait -> ld_data=0xFFFFFF80 at cycle 2; LBU at the same address gives 0x00000080.
REQ-038 LH at 0x42, rdata=0x8001_0000, ack after 4 cycles -> stall_req high 5 cycles, then ld_data=0xFFFF8001 with ld_valid one cycle.
REQ-039 Back-to-back LW/SW, zero-wait -> each access takes 3 cycles; no dm_req in DONE; the second request is issued from the IDLE cycle.
REQ-040 With MEM_ALIGN_EXC_EN: LW at 0x06 -> addr_exc=1, dm_req never asserted, stall_req=0.
